// File: rtl/tap_window_feeder_pkg.sv
// -----------------------------------------------------------------------------
// tap_window_feeder_pkg
//
// Definitions shared by the tap window feeder and its paired adder tree.
//   fill_state_t        : window fill state (EMPTY / FILL / FULL)
//   adder_tree_latency  : pipeline latency of adder_tree_log for a given
//                         operand count and piping start stage. Both blocks
//                         derive their latency from this one function so
//                         they cannot disagree.
// -----------------------------------------------------------------------------
package tap_window_feeder_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } fill_state_t;

    // The tree has $clog2(len) reduction stages, numbered 0..MAXS. Registers
    // are inserted from piping_start_stage upward, one every (pss+1) stages.
    function automatic int adder_tree_latency(input int len, input int pss);
        int maxs;
        maxs = $clog2(len) - 1;
        if (maxs - pss > 0) begin
            return (maxs - pss - 1) / (pss + 1) + 1;
        end
        return 0;
    endfunction

endpackage

// File: rtl/tap_window_feeder_if.sv
// -----------------------------------------------------------------------------
// tap_window_feeder_if
//
// Sample stream in, tap window out.
//   in_valid    : sample offered
//   in_sample   : signed sample, WIDTH bits
//   in_ready    : sample accepted when in_valid && in_ready
//   taps_packed : LEN taps, tap k at [WIDTH*k +: WIDTH], tap 0 newest
//   taps_valid  : one-cycle strobe, window just advanced and is full
//   sum_valid   : taps_valid delayed by the adder tree latency
//   fill_count  : accepted samples, saturating at LEN
//
// master : the sample producer / window consumer
// slave  : the feeder itself
// -----------------------------------------------------------------------------
interface tap_window_feeder_if #(
    parameter int WIDTH = 16,
    parameter int LEN   = 1024
);
    localparam int CNT_W = $clog2(LEN + 1);

    logic                     in_valid;
    logic signed [WIDTH-1:0]  in_sample;
    logic                     in_ready;
    logic [LEN*WIDTH-1:0]     taps_packed;
    logic                     taps_valid;
    logic                     sum_valid;
    logic [CNT_W-1:0]         fill_count;

    modport master (
        output in_valid,
        output in_sample,
        input  in_ready,
        input  taps_packed,
        input  taps_valid,
        input  sum_valid,
        input  fill_count
    );

    modport slave (
        input  in_valid,
        input  in_sample,
        output in_ready,
        output taps_packed,
        output taps_valid,
        output sum_valid,
        output fill_count
    );

endinterface

// File: rtl/tap_window_feeder_delay.sv
// -----------------------------------------------------------------------------
// tap_window_feeder_delay
//
// DEPTH-stage register delay line (DelayNUnit behaviour) with an added
// synchronous clear so a window flush can discard strobes still in flight.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, empties every stage
//   clr   : synchronous clear, empties every stage, input is not loaded
//   din   : value entering the line
//   dout  : din delayed by DEPTH cycles
// DEPTH must be at least 1; zero-latency users bypass this module.
// -----------------------------------------------------------------------------
module tap_window_feeder_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i] <= '0;
            end
        end else begin
            stage_p[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/tap_window_feeder.sv
// -----------------------------------------------------------------------------
// tap_window_feeder
//
// Serial-to-parallel tap delay line feeding adder_tree_log. Each accepted
// sample shifts into a LEN-deep window presented as one packed operand
// vector; a result strobe follows the adder tree latency so downstream
// logic knows when the tree output is the sum of a full window.
//
// Parameters
//   WIDTH              : sample width, equal to the adder tree WIDTH
//   LEN                : window depth, power of two, >= 2
//   piping_start_stage : same value as the paired adder tree (latency only)
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous window clear; drops any sample offered with it
//   bus   : sample stream in / window and strobes out (slave side)
// -----------------------------------------------------------------------------
module tap_window_feeder
    import tap_window_feeder_pkg::*;
#(
    parameter int WIDTH              = 16,
    parameter int LEN                = 1024,
    parameter int piping_start_stage = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    tap_window_feeder_if.slave   bus
);

    localparam int               LAT      = adder_tree_latency(LEN, piping_start_stage);
    localparam int               CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    fill_state_t          state;
    logic [LEN*WIDTH-1:0] taps_p0;
    logic [CNT_W-1:0]     fill_count;
    logic                 vld_p0;
    logic                 sum_vld;

    // ---- stage 0: window shift, fill tracking, full-window strobe ----
    // The strobe is raised on every accept that leaves the window full:
    // the one completing the fill and every accept while already FULL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            taps_p0    <= '0;
            fill_count <= '0;
            vld_p0     <= 1'b0;
        end else if (flush) begin
            state      <= ST_EMPTY;
            taps_p0    <= '0;
            fill_count <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (bus.in_valid) begin
                taps_p0 <= {taps_p0[(LEN-1)*WIDTH-1:0], bus.in_sample};
                case (state)
                    ST_EMPTY, ST_FILL: begin
                        fill_count <= fill_count + 1'b1;
                        if (fill_count == LAST_CNT) begin
                            state  <= ST_FULL;
                            vld_p0 <= 1'b1;
                        end else begin
                            state  <= ST_FILL;
                        end
                    end
                    ST_FULL: begin
                        vld_p0 <= 1'b1;
                    end
                    default: begin
                        state      <= ST_EMPTY;
                        fill_count <= '0;
                    end
                endcase
            end
        end
    end

    // ---- stages 1..LAT: strobe alignment with the adder tree output ----
    generate
        if (LAT == 0) begin : g_no_delay
            assign sum_vld = vld_p0;
        end else begin : g_delay
            tap_window_feeder_delay #(
                .WIDTH (1),
                .DEPTH (LAT)
            ) u_sum_vld_delay (
                .clk   (clk),
                .reset (reset),
                .clr   (flush),
                .din   (vld_p0),
                .dout  (sum_vld)
            );
        end
    endgenerate

    // Flush is the only reason to refuse a sample.
    assign bus.in_ready    = ~flush;
    assign bus.taps_packed = taps_p0;
    assign bus.taps_valid  = vld_p0;
    assign bus.sum_valid   = sum_vld;
    assign bus.fill_count  = fill_count;

endmodule

// File: tb/tb_tap_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_tap_window_feeder
//
// Three feeders side by side:
//   A : LEN=8,    pss=0  (latency 2)
//   B : LEN=8,    pss=3  (latency 0)
//   C : LEN=1024, pss=3  (latency 2)
// A window model (list of accepted samples, newest first) predicts every
// output each cycle; directed steps pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_tap_window_feeder;

    localparam int W = 16;

    logic                clk;
    logic                reset;
    logic                vin  [3];
    logic signed [W-1:0] samp [3];
    logic                fl   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tap_window_feeder_if #(.WIDTH(W), .LEN(8))    bus_a ();
    tap_window_feeder_if #(.WIDTH(W), .LEN(8))    bus_b ();
    tap_window_feeder_if #(.WIDTH(W), .LEN(1024)) bus_c ();

    assign bus_a.in_valid  = vin[0];
    assign bus_a.in_sample = samp[0];
    assign bus_b.in_valid  = vin[1];
    assign bus_b.in_sample = samp[1];
    assign bus_c.in_valid  = vin[2];
    assign bus_c.in_sample = samp[2];

    tap_window_feeder #(.WIDTH(W), .LEN(8), .piping_start_stage(0)) dut_a (
        .clk(clk), .reset(reset), .flush(fl[0]), .bus(bus_a));
    tap_window_feeder #(.WIDTH(W), .LEN(8), .piping_start_stage(3)) dut_b (
        .clk(clk), .reset(reset), .flush(fl[1]), .bus(bus_b));
    tap_window_feeder #(.WIDTH(W), .LEN(1024), .piping_start_stage(3)) dut_c (
        .clk(clk), .reset(reset), .flush(fl[2]), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT accessors ----------------
    function automatic int len_of(input int g);
        return (g == 2) ? 1024 : 8;
    endfunction

    // Hand-derived: LEN=8,pss=0 -> 2 ; LEN=8,pss=3 -> 0 ; LEN=1024,pss=3 -> 2
    function automatic int lat_of(input int g);
        return (g == 1) ? 0 : 2;
    endfunction

    function automatic int tap_of(input int g, input int k);
        int v;
        case (g)
            0:       v = $signed(bus_a.taps_packed[k*W +: W]);
            1:       v = $signed(bus_b.taps_packed[k*W +: W]);
            default: v = $signed(bus_c.taps_packed[k*W +: W]);
        endcase
        return v;
    endfunction

    function automatic int fc_of(input int g);
        case (g)
            0:       return int'(bus_a.fill_count);
            1:       return int'(bus_b.fill_count);
            default: return int'(bus_c.fill_count);
        endcase
    endfunction

    function automatic int tv_of(input int g);
        case (g)
            0:       return int'(bus_a.taps_valid);
            1:       return int'(bus_b.taps_valid);
            default: return int'(bus_c.taps_valid);
        endcase
    endfunction

    function automatic int sv_of(input int g);
        case (g)
            0:       return int'(bus_a.sum_valid);
            1:       return int'(bus_b.sum_valid);
            default: return int'(bus_c.sum_valid);
        endcase
    endfunction

    function automatic int rdy_of(input int g);
        case (g)
            0:       return int'(bus_a.in_ready);
            1:       return int'(bus_b.in_ready);
            default: return int'(bus_c.in_ready);
        endcase
    endfunction

    function automatic int sum_taps(input int g);
        int s = 0;
        for (int k = 0; k < len_of(g); k++) s += tap_of(g, k);
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- window model ----------------
    int win  [3][1024];
    int wsz  [3];
    bit etv  [3];
    bit pend [3][2];
    int tvq [$];
    int tv_cnt = 0;
    int sv_cnt = 0;

    task automatic model_clear(input int g);
        wsz[g]     = 0;
        etv[g]     = 1'b0;
        pend[g][0] = 1'b0;
        pend[g][1] = 1'b0;
        for (int k = 0; k < 1024; k++) win[g][k] = 0;
    endtask

    task automatic model_compare(input int g);
        int bad;
        int esv;
        chk($sformatf("fill_count[%0d]", g), fc_of(g), wsz[g]);
        chk($sformatf("taps_valid[%0d]", g), tv_of(g), int'(etv[g]));
        if (lat_of(g) == 0) esv = int'(etv[g]);
        else                esv = int'(pend[g][lat_of(g)-1]);
        chk($sformatf("sum_valid[%0d]", g), sv_of(g), esv);
        chk($sformatf("in_ready[%0d]", g), rdy_of(g), int'(!fl[g]));
        bad = -1;
        for (int k = 0; k < len_of(g); k++) begin
            if (bad < 0 && tap_of(g, k) != win[g][k]) bad = k;
        end
        chk($sformatf("tap_mismatch_index[%0d]", g), bad, -1);
    endtask

    // Effect of the coming rising edge given the inputs now on the bus.
    task automatic model_step(input int g);
        if (fl[g]) begin
            model_clear(g);
        end else begin
            for (int i = lat_of(g) - 1; i >= 1; i--) pend[g][i] = pend[g][i-1];
            if (lat_of(g) > 0) pend[g][0] = etv[g];
            if (vin[g]) begin
                for (int k = len_of(g) - 1; k >= 1; k--) win[g][k] = win[g][k-1];
                win[g][0] = samp[g];
                if (wsz[g] < len_of(g)) wsz[g]++;
            end
            etv[g] = vin[g] && (wsz[g] == len_of(g));
        end
    endtask

    initial begin : compare_proc
        for (int g = 0; g < 3; g++) model_clear(g);
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (!reset) model_clear(g);
                model_compare(g);
                if (reset) model_step(g);
            end
            if (!reset) begin
                tvq.delete();
            end else begin
                if (tv_of(2) != 0) begin
                    tvq.push_back(cyc);
                    tv_cnt++;
                end
                if (sv_of(2) != 0) begin
                    sv_cnt++;
                    chk("lag_c_pending", (tvq.size() > 0) ? 1 : 0, 1);
                    if (tvq.size() > 0) chk("lag_c_cycles", cyc - tvq.pop_front(), 2);
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int g, input int v);
        vin[g]  = 1'b1;
        samp[g] = W'(v);
        @(posedge clk);
        #1;
        vin[g]  = 1'b0;
    endtask

    initial begin : stim
        for (int g = 0; g < 3; g++) begin
            vin[g]  = 1'b0;
            samp[g] = '0;
            fl[g]   = 1'b0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_fill_count[%0d]", g), fc_of(g), 0);
            chk($sformatf("rst_taps_valid[%0d]", g), tv_of(g), 0);
            chk($sformatf("rst_sum_valid[%0d]", g), sv_of(g), 0);
            chk($sformatf("rst_in_ready[%0d]", g), rdy_of(g), 1);
        end

        // A: fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            push(0, i);
            chk("a_fill_count", fc_of(0), i);
            if (i < 8) chk("a_taps_valid_early", tv_of(0), 0);
        end
        chk("a_full_taps_valid", tv_of(0), 1);
        chk("a_full_tap0", tap_of(0, 0), 8);
        chk("a_full_tap7", tap_of(0, 7), 1);
        chk("a_full_sum", sum_taps(0), 36);
        chk("a_sv_lat0", sv_of(0), 0);
        idle(1);
        chk("a_sv_lat1", sv_of(0), 0);
        chk("a_tv_single", tv_of(0), 0);
        idle(1);
        chk("a_sv_lat2", sv_of(0), 1);
        idle(1);
        chk("a_sv_after", sv_of(0), 0);

        // A: 9 and 10 back to back while full
        push(0, 9);
        chk("a9_tv", tv_of(0), 1);
        chk("a9_tap0", tap_of(0, 0), 9);
        chk("a9_tap7", tap_of(0, 7), 2);
        chk("a9_sum", sum_taps(0), 44);
        push(0, 10);
        chk("a10_tv", tv_of(0), 1);
        chk("a10_tap7", tap_of(0, 7), 3);
        chk("a10_sum", sum_taps(0), 52);
        chk("a10_sv", sv_of(0), 0);
        idle(1);
        chk("a9_sv", sv_of(0), 1);
        idle(1);
        chk("a10_sv_aligned", sv_of(0), 1);
        idle(1);
        chk("a_sv_gap", sv_of(0), 0);

        // B: eight -1 samples, zero latency
        for (int i = 1; i <= 8; i++) begin
            push(1, -1);
            if (i < 8) chk("b_sv_early", sv_of(1), 0);
        end
        chk("b_tv", tv_of(1), 1);
        chk("b_sv_same_cycle", sv_of(1), 1);
        chk("b_sum", sum_taps(1), -8);
        idle(1);
        chk("b_sv_after", sv_of(1), 0);

        // A: flush with a sample offered while strobes are in flight
        push(0, 11);
        push(0, 12);
        fl[0]   = 1'b1;
        vin[0]  = 1'b1;
        samp[0] = W'(99);
        #1;
        chk("flush_in_ready", rdy_of(0), 0);
        @(posedge clk);
        #1;
        fl[0]  = 1'b0;
        vin[0] = 1'b0;
        chk("flush_fill_count", fc_of(0), 0);
        chk("flush_taps_zero", sum_taps(0), 0);
        chk("flush_tap0_dropped", tap_of(0, 0), 0);
        chk("flush_tv", tv_of(0), 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("flush_no_stale_sv", sv_of(0), 0);
        end
        for (int i = 1; i <= 8; i++) begin
            push(0, 20 + i);
            chk("refill_tv", tv_of(0), (i == 8) ? 1 : 0);
        end
        chk("refill_sum", sum_taps(0), 196);
        idle(3);

        // A: asynchronous reset mid-fill
        fl[0] = 1'b1;
        idle(1);
        fl[0] = 1'b0;
        for (int i = 1; i <= 5; i++) push(0, 30 + i);
        chk("prereset_fill_count", fc_of(0), 5);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_fill_count", fc_of(0), 0);
        chk("async_rst_taps", sum_taps(0), 0);
        chk("async_rst_tv", tv_of(0), 0);
        chk("async_rst_sv", sv_of(0), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(0, 40 + i);
            chk("post_rst_tv", tv_of(0), (i == 8) ? 1 : 0);
        end
        idle(3);

        // C: random gaps on a 1024-deep window
        for (int n = 0; n < 3000; n++) begin
            vin[2]  = 1'($urandom_range(0, 1));
            samp[2] = W'($urandom);
            @(posedge clk);
            #1;
        end
        vin[2] = 1'b0;
        idle(4);
        chk("c_fill_count_full", fc_of(2), 1024);
        chk("c_pulse_counts_equal", sv_cnt, tv_cnt);
        chk("c_pulses_seen", (tv_cnt > 0) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tap_window_feeder.md
# tap_window_feeder

- Serial-to-parallel tap delay line feeding `adder_tree_log`.
- Accepts one WIDTH-bit sample per handshake, shifts it into a LEN-deep window, and presents the window as the packed LEN*WIDTH operand vector.
- Generates a result-valid strobe delayed by exactly the adder tree's pipeline latency, so downstream filter logic knows when the tree output is the sum of a full window.

## Interface
Parameters:
- `WIDTH`, 16: sample width in bits; equals the adder tree WIDTH.
- `LEN`, 1024: window depth (filter order); power of two, ≥ 2.
- `piping_start_stage`, 3: must equal the value given to the paired adder tree; used only to derive latency.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous window clear.
- `in_valid`, in, 1: sample offered.
- `in_sample`, in, WIDTH: signed sample.
- `in_ready`, out, 1: sample accepted when `in_valid && in_ready`.
- `taps_packed`, out, LEN*WIDTH: window. Tap k occupies bits [WIDTH*k +: WIDTH]. Tap 0 is the newest sample.
- `taps_valid`, out, 1: one-cycle strobe; the window just advanced and is full.
- `sum_valid`, out, 1: `taps_valid` delayed by LAT cycles; aligned with `adder_tree_out`.
- `fill_count`, out, $clog2(LEN+1): number of accepted samples, saturating at LEN.

## Operation
- LAT, the adder tree latency, is derived as follows:
  - Let MAXS = $clog2(LEN)-1.
  - If MAXS - piping_start_stage > 0: LAT = (MAXS - piping_start_stage - 1)/(piping_start_stage+1) + 1, using integer division.
  - Otherwise LAT = 0.
  - Example: LEN=1024, pss=3 gives LAT=2.
- States and transitions:
  - EMPTY: fill_count=0.
  - FILL: 0 < fill_count < LEN.
  - FULL: fill_count=LEN.
  - EMPTY→FILL on accept; FILL→FULL on the accept that makes the count LEN; FULL stays FULL on accept.
  - Any state →EMPTY on `flush`.
- On accept (not flushing):
  - Taps shift: tap[k] ← tap[k-1] for k=1..LEN-1, and tap[0] ← in_sample.
  - fill_count increments, saturating at LEN.
- `taps_valid` is registered. It is 1 in the cycle after an accept whose resulting fill_count = LEN; otherwise 0. There is one pulse per accepted sample in FULL.
- `in_ready` = !flush. The block never back-pressures otherwise; a sample is accepted every cycle `in_valid` is high.
- Flush:
  - Clears all taps to 0 and fill_count to 0.
  - Forces `taps_valid` to 0 next cycle.
  - Clears every stage of the sum_valid delay line, so no stale strobe emerges.
  - Flush with `in_valid` in the same cycle: flush wins and the sample is dropped (in_ready=0 that cycle).
- Samples are stored bit-exact. No arithmetic is performed in this block.

## Timing
- Reset (reset=0), asynchronous:
  - All taps 0, fill_count 0, state EMPTY.
  - taps_valid 0, sum_valid 0, whole valid delay line 0.
  - in_ready reads 1 once flush=0.
- Reset mid-operation: the window is lost and behaviour is identical to power-up. Release is synchronous to clk in the surrounding design.
- Accept at edge N: taps_packed and fill_count reflect the new sample after edge N.
- taps_valid:
  - High during cycle N+1 when full.
  - sum_valid is high during cycle N+1+LAT.
  - With LAT=0, sum_valid equals taps_valid.
- Back-to-back accepts in FULL give continuous taps_valid/sum_valid. Gaps in in_valid produce matching gaps.
- fill_count never exceeds LEN; no wrap.

## Structure
- Shared package/header holds:
  - The LAT function (adder_tree_latency(LEN, piping_start_stage)), so the adder tree and this block cannot disagree.
  - State encodings EMPTY/FILL/FULL.
- The valid delay line uses the existing `DelayNUnit` instantiated with width 1 and depth LAT. It is bypassed by generate when LAT=0.
- The flush clear must also reach `DelayNUnit`. Add a synchronous-clear input to it, or implement the valid delay locally with the same behaviour.
- The tap shift register is inline; no further sub-modules.

## Test plan
- Reset, then LEN=8, WIDTH=16, pss=0 (LAT=2). Push samples 1..8 on consecutive cycles.
  - Required: fill_count runs 1..8.
  - taps_valid is first high the cycle after sample 8, with taps[0..7]=8,7,…,1.
  - sum_valid is high 2 cycles later, and the paired adder_tree_out=36.
- Same config, push 9 and 10 back-to-back after full.
  - Required: taps_valid high two consecutive cycles, with windows 9..2 and 10..3.
  - Sums are 44 and 52, each with sum_valid aligned.
- LEN=8, pss=3 (LAT=0), signed samples -1 ×8.
  - Required: sum_valid == taps_valid in the same cycle, and the sum is -8.
- Full window: assert flush together with in_valid (sample 99) while sum_valid strobes are in flight.
  - Required: in_ready=0, sample dropped.
  - Taps all 0 and fill_count 0 next cycle.
  - No sum_valid pulse afterwards.
  - Refill requires 8 new samples.
- Pull reset low mid-fill (fill_count=5) between edges.
  - Required: outputs go to reset values immediately, without waiting for a clock edge.
  - After release, 8 samples are needed before taps_valid.
- Random in_valid with 50% gaps, LEN=1024, pss=3.
  - Required: the sum_valid pulse count equals the taps_valid count.
  - Each sum_valid lags its taps_valid by exactly 2 cycles.
